// File: rtl/spi_pkg.sv
// Shared definitions for the SPI read scheduler: FSM state encoding,
// polarity constants and the index-width helper used for port sizing.
package spi_pkg;

    // Transfer sequencing states
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        TRAIL,
        GAP
    } spi_state_t;

    // Polarity encodings for the slave-select and serial-clock outputs
    localparam logic SS_ACTIVE_HIGH = 1'b1;
    localparam logic SS_ACTIVE_LOW  = 1'b0;
    localparam logic SCLK_IDLE_HIGH = 1'b1;
    localparam logic SCLK_IDLE_LOW  = 1'b0;

    // Width of an index into n items; never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Request arbiter for the SPI read scheduler. Produces a one-hot grant and
// the matching index from a level request vector.
// Build option: SPI_READ_SCHEDULER_FIXED_PRIORITY_EN selects fixed priority
// (lowest index wins, no pointer); otherwise round robin starting after the
// last winner.
module spi_rr_arbiter
    import spi_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = idx_width(N)
) (
    input  logic          i_clock,
    input  logic          i_reset_n,
    input  logic [N-1:0]  i_request,
    input  logic          i_update,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_index,
    output logic          o_any
);

`ifdef SPI_READ_SCHEDULER_FIXED_PRIORITY_EN

    // The pointer is not built here; clock, reset and update are unused
    logic w_unused_fixed;
    assign w_unused_fixed = ^{i_clock, i_reset_n, i_update};

    // Lowest set request index wins
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        o_grant = '0;
        o_index = '0;
        o_any   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!o_any && i_request[i]) begin
                o_any      = 1'b1;
                o_grant[i] = 1'b1;
                o_index    = IW'(i);
            end
        end
    end

`else

    logic [IW-1:0] r_ptr;
    int            w_idx;

    // Remember the last winner; reset value makes requester 0 win first
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (!i_reset_n) begin
            r_ptr <= IW'(N - 1);
        end else if (i_update) begin
            r_ptr <= o_index;
        end
    end

    // Search from the index after the last winner, wrapping to 0
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        o_grant = '0;
        o_index = '0;
        o_any   = 1'b0;
        w_idx   = 0;
        for (int i = 0; i < N; i++) begin
            w_idx = int'(r_ptr) + 1 + i;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (!o_any && i_request[w_idx]) begin
                o_any          = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_index        = IW'(w_idx);
            end
        end
    end

`endif

endmodule

// File: rtl/spi_read_scheduler.sv
// Sequencing SPI master: arbitrates read requests, frames one CPHA=1 word
// per grant, and returns the word tagged with the requester index.
// Build option: SPI_READ_SCHEDULER_FIXED_PRIORITY_EN (see spi_rr_arbiter).
module spi_read_scheduler
    import spi_pkg::*;
#(
    parameter  int   REQUESTERS    = 4,
    parameter  int   BITCOUNT      = 16,
    parameter  int   HALF_PERIOD   = 4,
    parameter  logic SS_POLARITY   = SS_ACTIVE_LOW,
    parameter  logic SCLK_POLARITY = SCLK_IDLE_HIGH,
    parameter  logic MSB_FIRST     = 1'b1,
    localparam int   CW            = idx_width(REQUESTERS)
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic [REQUESTERS-1:0] i_request,
    output logic [REQUESTERS-1:0] o_grant,
    output logic                  o_ss,
    output logic                  o_sclk,
    input  logic                  i_sdi,
    output logic [BITCOUNT-1:0]   o_data,
    output logic [CW-1:0]         o_data_channel,
    output logic                  o_data_valid
);

    localparam int HP_W   = $clog2(HALF_PERIOD) + 1;
    localparam int EDGE_W = $clog2(2 * BITCOUNT) + 1;
    localparam logic [HP_W-1:0]   HP_LAST   = HP_W'(HALF_PERIOD - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * BITCOUNT - 1);

    spi_state_t              r_state;
    spi_state_t              w_next_state;
    logic [HP_W-1:0]         r_hp_cnt;
    logic [EDGE_W-1:0]       r_edge_cnt;
    logic                    r_sclk;
    logic [BITCOUNT-1:0]     r_shift;
    logic [REQUESTERS-1:0]   r_grant;
    logic [CW-1:0]           r_channel;
    logic [BITCOUNT-1:0]     r_data;
    logic [CW-1:0]           r_data_channel;
    logic                    r_data_valid;

    logic                    w_hp_done;
    logic                    w_last_edge;
    logic                    w_start;
    logic                    w_ss_active;
    logic [REQUESTERS-1:0]   w_arb_grant;
    logic [CW-1:0]           w_arb_index;
    logic                    w_arb_any;

    assign w_hp_done   = (r_hp_cnt == HP_LAST);
    assign w_last_edge = (r_edge_cnt == EDGE_LAST);
    assign w_start     = (r_state == IDLE) && w_arb_any;

    spi_rr_arbiter #(
        .N (REQUESTERS)
    ) u_arbiter (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_request (i_request),
        .i_update  (w_start),
        .o_grant   (w_arb_grant),
        .o_index   (w_arb_index),
        .o_any     (w_arb_any)
    );

    // FSM state register
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state: each timed state lasts whole half periods
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_arb_any)                w_next_state = SETUP;
            SETUP:   if (w_hp_done)                w_next_state = SHIFT;
            SHIFT:   if (w_hp_done && w_last_edge) w_next_state = TRAIL;
            TRAIL:   if (w_hp_done)                w_next_state = GAP;
            GAP:     if (w_hp_done)                w_next_state = IDLE;
            default:                               w_next_state = IDLE;
        endcase
    end

    // FSM outputs: slave-select, grant and serial clock follow the state
    always_comb begin
        w_ss_active = (r_state == SETUP) || (r_state == SHIFT) || (r_state == TRAIL);
        o_ss        = w_ss_active ? SS_POLARITY : ~SS_POLARITY;
        o_grant     = w_ss_active ? r_grant : '0;
        o_sclk      = (SCLK_POLARITY == SCLK_IDLE_HIGH) ? r_sclk : ~r_sclk;
    end

    // Half-period counter: restarts at each half-period boundary, parked in IDLE
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_hp_cnt <= '0;
        end else if ((r_state == IDLE) || w_hp_done) begin
            r_hp_cnt <= '0;
        end else begin
            r_hp_cnt <= r_hp_cnt + 1'b1;
        end
    end

    // Serial clock (normalised idle-high) and edge counter, active in SHIFT only
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sclk     <= 1'b1;
            r_edge_cnt <= '0;
        end else if (r_state != SHIFT) begin
            r_sclk     <= 1'b1;
            r_edge_cnt <= '0;
        end else if (w_hp_done) begin
            r_sclk     <= ~r_sclk;
            r_edge_cnt <= r_edge_cnt + 1'b1;
        end
    end

    // Sample sdi on each trailing (low-to-high) edge of the normalised clock
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        // NOTE: the shift register is reset too, so no X can ever reach o_data.
        if (!i_reset_n) begin
            r_shift <= '0;
        end else if ((r_state == SHIFT) && w_hp_done && !r_sclk) begin
            if (MSB_FIRST) begin
                r_shift <= {r_shift[BITCOUNT-2:0], i_sdi};
            end else begin
                r_shift <= {i_sdi, r_shift[BITCOUNT-1:1]};
            end
        end
    end

    // Capture the winner when a transfer starts
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_grant   <= '0;
            r_channel <= '0;
        end else if (w_start) begin
            r_grant   <= w_arb_grant;
            r_channel <= w_arb_index;
        end
    end

    // Publish the word on TRAIL exit; valid lands in the first GAP cycle
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_data         <= '0;
            r_data_channel <= '0;
            r_data_valid   <= 1'b0;
        end else if ((r_state == TRAIL) && w_hp_done) begin
            r_data         <= r_shift;
            r_data_channel <= r_channel;
            r_data_valid   <= 1'b1;
        end else begin
            r_data_valid   <= 1'b0;
        end
    end

    assign o_data         = r_data;
    assign o_data_channel = r_data_channel;
    assign o_data_valid   = r_data_valid;

endmodule

// File: tb/tb_spi_read_scheduler.sv
// Directed bench for spi_read_scheduler: a main instance with default
// parameters and an alternate instance (LSB first, sclk idle low).
module tb_spi_read_scheduler;

    localparam int N        = 4;
    localparam int BC       = 16;
    localparam int HP       = 4;
    localparam int SS_LEN   = (2 * BC + 2) * HP;      // 136
    localparam int SPACING  = (2 * BC + 3) * HP + 1;  // 141

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [N-1:0]  grant;
    logic          ss, sclk, sdi;
    logic [BC-1:0] data;
    logic [1:0]    chan;
    logic          dv;

    logic [N-1:0]  alt_req;
    logic [N-1:0]  alt_grant;
    logic          alt_ss, alt_sclk, alt_sdi;
    logic [BC-1:0] alt_data;
    logic [1:0]    alt_chan;
    logic          alt_dv;

    always #5 clk = ~clk;

    spi_read_scheduler #(
        .REQUESTERS(N), .BITCOUNT(BC), .HALF_PERIOD(HP),
        .SS_POLARITY(1'b0), .SCLK_POLARITY(1'b1), .MSB_FIRST(1'b1)
    ) dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_request(req), .o_grant(grant),
        .o_ss(ss), .o_sclk(sclk), .i_sdi(sdi), .o_data(data),
        .o_data_channel(chan), .o_data_valid(dv)
    );

    spi_read_scheduler #(
        .REQUESTERS(N), .BITCOUNT(BC), .HALF_PERIOD(HP),
        .SS_POLARITY(1'b0), .SCLK_POLARITY(1'b0), .MSB_FIRST(1'b0)
    ) dut_alt (
        .i_clock(clk), .i_reset_n(rst_n), .i_request(alt_req), .o_grant(alt_grant),
        .o_ss(alt_ss), .o_sclk(alt_sclk), .i_sdi(alt_sdi), .o_data(alt_data),
        .o_data_channel(alt_chan), .o_data_valid(alt_dv)
    );

    // Word each requester's slave serialises, first bit = bit 15
    logic [BC-1:0] tx_word [N] = '{16'h1234, 16'h5678, 16'hA5C3, 16'hBEEF};
    logic [BC-1:0] alt_stream = 16'h8000;

    int n_checks = 0;
    int n_pass   = 0;

    // Monitor logs
    int cycle       = 0;
    int dv_count    = 0;
    int alt_dv_count = 0;
    int dv_ss_err   = 0;
    int overlap_err = 0;
    logic [BC-1:0] dv_data_q[$];
    int dv_chan_q[$];
    int grant_q[$];
    int grant_time_q[$];
    int ss_len_q[$];

    function automatic int onehot_idx(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return 0;
    endfunction

    // Main slave: presents the next bit on each leading (falling) sclk edge
    initial begin
        int   bit_i;
        logic prev;
        logic [BC-1:0] w;
        bit_i = BC - 1;
        prev  = 1'b1;
        sdi   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ss == 1'b0) begin
                if (prev == 1'b1 && sclk == 1'b0 && bit_i >= 0) begin
                    w     = tx_word[onehot_idx(grant)];
                    sdi   = w[bit_i];
                    bit_i = bit_i - 1;
                end
            end else begin
                bit_i = BC - 1;
            end
            prev = sclk;
        end
    end

    // Alternate slave: sclk idles low, so the leading edge is rising
    initial begin
        int   bit_i;
        logic prev;
        bit_i   = BC - 1;
        prev    = 1'b0;
        alt_sdi = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (alt_ss == 1'b0) begin
                if (prev == 1'b0 && alt_sclk == 1'b1 && bit_i >= 0) begin
                    alt_sdi = alt_stream[bit_i];
                    bit_i   = bit_i - 1;
                end
            end else begin
                bit_i = BC - 1;
            end
            prev = alt_sclk;
        end
    end

    // Monitor: logs grants, ss-active lengths and data_valid events
    initial begin
        logic [N-1:0] pg;
        int ss_len;
        pg     = '0;
        ss_len = 0;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (alt_dv) alt_dv_count++;
            if (dv) begin
                dv_count++;
                dv_data_q.push_back(data);
                dv_chan_q.push_back(int'(chan));
                if (ss == 1'b0) dv_ss_err++;
            end
            if ($countones(grant) > 1) overlap_err++;
            if (pg == '0 && grant != '0) begin
                grant_q.push_back(onehot_idx(grant));
                grant_time_q.push_back(cycle);
            end
            pg = grant;
            if (ss == 1'b0) begin
                ss_len++;
            end else if (ss_len != 0) begin
                ss_len_q.push_back(ss_len);
                ss_len = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        dv_count    = 0;
        dv_ss_err   = 0;
        overlap_err = 0;
        dv_data_q.delete();
        dv_chan_q.delete();
        grant_q.delete();
        grant_time_q.delete();
        ss_len_q.delete();
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req     = '0;
        alt_req = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        clear_logs();
    endtask

    task automatic wait_dv(input int target, input int budget, output bit ok);
        int i;
        i  = 0;
        ok = 1'b0;
        while (i < budget && !ok) begin
            if (dv_count >= target) ok = 1'b1;
            else begin
                tick();
                i++;
            end
        end
    endtask

    task automatic wait_sclk_edges(input int edges, input int budget, output bit ok);
        int   seen, i;
        logic prev;
        seen = 0;
        i    = 0;
        prev = sclk;
        ok   = 1'b0;
        while (i < budget && !ok) begin
            tick();
            i++;
            if (sclk !== prev) seen++;
            prev = sclk;
            if (seen >= edges) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        req     = '0;
        alt_req = '0;
        repeat (3) tick();
        n_checks++; if (grant !== 4'b0000) $display("FAIL reset_grant got %b want 0000", grant); else n_pass++;
        n_checks++; if (ss !== 1'b1) $display("FAIL reset_ss got %b want 1", ss); else n_pass++;
        n_checks++; if (sclk !== 1'b1) $display("FAIL reset_sclk got %b want 1", sclk); else n_pass++;
        n_checks++; if (data !== 16'h0000) $display("FAIL reset_data got %h want 0000", data); else n_pass++;
        n_checks++; if (chan !== 2'd0) $display("FAIL reset_chan got %0d want 0", chan); else n_pass++;
        n_checks++; if (dv !== 1'b0) $display("FAIL reset_dv got %b want 0", dv); else n_pass++;
        n_checks++; if (alt_sclk !== 1'b0) $display("FAIL reset_alt_sclk got %b want 0", alt_sclk); else n_pass++;
        rst_n = 1'b1;
        tick();
        clear_logs();
    endtask

    task automatic test_single();
        bit ok;
        req = 4'b0100;
        tick();
        n_checks++; if (grant !== 4'b0100) $display("FAIL single_grant_latency got %b want 0100", grant); else n_pass++;
        n_checks++; if (ss !== 1'b0) $display("FAIL single_ss_active got %b want 0", ss); else n_pass++;
        wait_dv(1, 400, ok);
        n_checks++; if (!ok) $display("FAIL single_dv_timeout got 0 want 1"); else n_pass++;
        req = '0;
        repeat (10) tick();
        n_checks++; if (dv_count !== 1) $display("FAIL single_dv_count got %0d want 1", dv_count); else n_pass++;
        n_checks++; if (data !== 16'hA5C3) $display("FAIL single_data got %h want a5c3", data); else n_pass++;
        n_checks++; if (chan !== 2'd2) $display("FAIL single_chan got %0d want 2", chan); else n_pass++;
        n_checks++; if (dv_ss_err !== 0) $display("FAIL single_dv_with_ss got %0d want 0", dv_ss_err); else n_pass++;
        n_checks++;
        if (ss_len_q.size() != 1 || ss_len_q[0] != SS_LEN)
            $display("FAIL single_ss_len got %0d (n=%0d) want %0d",
                     (ss_len_q.size() > 0) ? ss_len_q[0] : -1, ss_len_q.size(), SS_LEN);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        bit ok;
        int i;
        int exp_rr [4];
`ifdef SPI_READ_SCHEDULER_FIXED_PRIORITY_EN
        exp_rr = '{0, 0, 0, 0};
`else
        exp_rr = '{0, 3, 0, 3};
`endif
        do_reset();
        req = 4'b1001;
        i = 0;
        while (grant_q.size() < 4 && i < 800) begin
            tick();
            i++;
        end
        req = '0;
        wait_dv(4, 300, ok);
        n_checks++; if (!ok) $display("FAIL rr_dv_timeout got %0d want 4", dv_count); else n_pass++;
        n_checks++; if (grant_q.size() != 4) $display("FAIL rr_grant_count got %0d want 4", grant_q.size()); else n_pass++;
        for (int k = 0; k < 4 && k < grant_q.size(); k++) begin
            n_checks++;
            if (grant_q[k] != exp_rr[k]) $display("FAIL rr_grant%0d got %0d want %0d", k, grant_q[k], exp_rr[k]);
            else n_pass++;
        end
        if (grant_time_q.size() >= 2) begin
            n_checks++;
            if (grant_time_q[1] - grant_time_q[0] != SPACING)
                $display("FAIL rr_spacing got %0d want %0d", grant_time_q[1] - grant_time_q[0], SPACING);
            else n_pass++;
        end
        repeat (8) tick();
    endtask

    task automatic test_back_to_back();
        int i;
        logic [N-1:0] done;
        do_reset();
        req  = 4'hF;
        done = '0;
        i    = 0;
        while (dv_count < 4 && i < 800) begin
            tick();
            i++;
            foreach (dv_chan_q[k]) done[dv_chan_q[k]] = 1'b1;
            req = 4'hF & ~done;
        end
        req = '0;
        repeat (10) tick();
        n_checks++; if (dv_count !== 4) $display("FAIL b2b_dv_count got %0d want 4", dv_count); else n_pass++;
        n_checks++; if (overlap_err !== 0) $display("FAIL b2b_overlap got %0d want 0", overlap_err); else n_pass++;
        for (int k = 0; k < 4 && k < grant_q.size(); k++) begin
            n_checks++;
            if (grant_q[k] != k) $display("FAIL b2b_grant%0d got %0d want %0d", k, grant_q[k], k);
            else n_pass++;
        end
        for (int k = 0; k < 4 && k < dv_data_q.size(); k++) begin
            n_checks++;
            if (dv_chan_q[k] != k || dv_data_q[k] !== tx_word[k])
                $display("FAIL b2b_word%0d got ch%0d %h want ch%0d %h", k, dv_chan_q[k], dv_data_q[k], k, tx_word[k]);
            else n_pass++;
        end
        for (int k = 1; k < 4 && k < grant_time_q.size(); k++) begin
            n_checks++;
            if (grant_time_q[k] - grant_time_q[k-1] != SPACING)
                $display("FAIL b2b_spacing%0d got %0d want %0d", k, grant_time_q[k] - grant_time_q[k-1], SPACING);
            else n_pass++;
        end
        foreach (ss_len_q[k]) begin
            n_checks++;
            if (ss_len_q[k] != SS_LEN) $display("FAIL b2b_ss_len%0d got %0d want %0d", k, ss_len_q[k], SS_LEN);
            else n_pass++;
        end
    endtask

    task automatic test_lsb_first_low_sclk();
        int i;
        alt_req = 4'b0001;
        i = 0;
        while (alt_dv_count < 1 && i < 400) begin
            tick();
            i++;
        end
        alt_req = '0;
        repeat (8) tick();
        n_checks++; if (alt_dv_count !== 1) $display("FAIL alt_dv_count got %0d want 1", alt_dv_count); else n_pass++;
        n_checks++; if (alt_data !== 16'h0001) $display("FAIL alt_data got %h want 0001", alt_data); else n_pass++;
        n_checks++; if (alt_chan !== 2'd0) $display("FAIL alt_chan got %0d want 0", alt_chan); else n_pass++;
        n_checks++; if (alt_sclk !== 1'b0) $display("FAIL alt_sclk_idle got %b want 0", alt_sclk); else n_pass++;
    endtask

    task automatic test_reset_mid_shift();
        bit ok;
        int dv_before;
        do_reset();
        req = 4'b0010;
        wait_sclk_edges(10, 300, ok);
        n_checks++; if (!ok) $display("FAIL rst_mid_edge_timeout got 0 want 1"); else n_pass++;
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++; if (ss !== 1'b1) $display("FAIL rst_mid_ss got %b want 1", ss); else n_pass++;
        n_checks++; if (sclk !== 1'b1) $display("FAIL rst_mid_sclk got %b want 1", sclk); else n_pass++;
        n_checks++; if (grant !== 4'b0000) $display("FAIL rst_mid_grant got %b want 0000", grant); else n_pass++;
        dv_before = dv_count;
        repeat (3) tick();
        rst_n = 1'b1;
        n_checks++; if (dv_count !== dv_before) $display("FAIL rst_mid_no_dv got %0d want %0d", dv_count, dv_before); else n_pass++;
        tick();
        n_checks++; if (grant !== 4'b0010) $display("FAIL rst_mid_regrant got %b want 0010", grant); else n_pass++;
        wait_dv(dv_before + 1, 400, ok);
        req = '0;
        n_checks++;
        if (!ok || data !== 16'h5678 || chan !== 2'd1)
            $display("FAIL rst_mid_after got ch%0d %h want ch1 5678", chan, data);
        else n_pass++;
        repeat (8) tick();
    endtask

    task automatic test_drop_mid_shift();
        bit ok;
        clear_logs();
        req = 4'b1000;
        wait_sclk_edges(5, 300, ok);
        req = '0;
        wait_dv(1, 400, ok);
        n_checks++; if (!ok) $display("FAIL drop_dv_timeout got 0 want 1"); else n_pass++;
        repeat (8) tick();
        n_checks++; if (chan !== 2'd3) $display("FAIL drop_chan got %0d want 3", chan); else n_pass++;
        n_checks++; if (data !== 16'hBEEF) $display("FAIL drop_data got %h want beef", data); else n_pass++;
        n_checks++;
        if (ss_len_q.size() != 1 || ss_len_q[0] != SS_LEN)
            $display("FAIL drop_ss_len got %0d want %0d", (ss_len_q.size() > 0) ? ss_len_q[0] : -1, SS_LEN);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_lsb_first_low_sclk();
        test_reset_mid_shift();
        test_drop_mid_shift();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_read_scheduler.md
# spi_read_scheduler

Sequencing SPI master that shares one serial input bus between several requesters (e.g. per-channel ADC readers). It arbitrates pending read requests, drives slave-select and serial clock, shifts in a fixed-width word from the serial data input, and returns the word tagged with the requester index. It sits between the requesting logic and the board-level SPI pins, producing CPHA = 1 framing compatible with the team's SPI receiver.

## Interface
- requesters, 4, number of requesters (≥1)
- bitcount, 16, bits per transfer (≥2)
- half_period, 4, clock cycles per serial-clock half period (≥1)
- ss_polarity, 0, 1 = active-high, 0 = active-low slave-select
- sclk_polarity, 1, CPOL: serial-clock idle level
- msb_first, 1, 1 = first received bit lands in the MSB
- clock  in  1  system clock; all logic on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- request  in  requesters  level request per requester; held until granted transfer completes
- grant  out  requesters  one-hot owner of the bus during a transfer; 0 otherwise
- ss  out  1  slave-select, polarity per ss_polarity
- sclk  out  1  serial clock, idle level per sclk_polarity
- sdi  in  1  serial data input
- data  out  bitcount  last received word
- data_channel  out  $clog2(requesters) (min 1)  index of requester that owns data
- data_valid  out  1  one-cycle pulse when data/data_channel update

## Operation
- Internal sclk normalized to CPOL = 1 (idle high); leading edge falling, trailing edge rising; output inverted when sclk_polarity = 0.
- States: IDLE, SETUP, SHIFT, TRAIL, GAP.
- IDLE: ss inactive, sclk idle, grant 0. Any request bit set -> pick winner, load grant, assert ss, go SETUP.
- SETUP: half_period cycles, then SHIFT.
- SHIFT: 2·bitcount half periods; sclk toggles at end of each. On each toggle to idle level (trailing edge) sdi is sampled into shift register (msb_first: shift left, insert at bit 0; else shift right, insert at MSB). After last toggle -> TRAIL.
- TRAIL: half_period cycles, sclk idle, ss still active; on exit ss deasserts, grant clears, shift register copied to data, winner index to data_channel, data_valid pulses, go GAP.
- GAP: half_period cycles ss inactive, then IDLE.
- Arbitration round robin: search starts at index after last winner, wraps to 0.
- Request deassertion mid-transfer does not abort; transfer completes, result delivered normally.
- data/data_channel hold value until next data_valid.
- Counters: half-period counter $clog2(half_period)+1 bits; edge counter $clog2(2·bitcount)+1 bits; no wrap inside a transfer.

## Timing
- Reset values: grant 0, ss inactive level, sclk idle level, data 0, data_channel 0, data_valid 0, state IDLE, round-robin pointer so requester 0 wins first.
- Reset assertion mid-transfer aborts immediately to reset values; no data_valid.
- Request sampled in IDLE; grant and ss active from next cycle.
- ss active duration: (2·bitcount + 2)·half_period cycles.
- data_valid asserted in first GAP cycle, concurrent with ss inactive.
- Request-to-next-grant minimum spacing: (2·bitcount + 3)·half_period + 1 cycles between consecutive grants.
- Simultaneous requests: exactly one granted; others wait, no loss.

## Configuration
- SPI_READ_SCHEDULER_FIXED_PRIORITY_EN defined: fixed priority, lowest requester index always wins; round-robin pointer not built.
- Undefined: round-robin arbitration as above.

## Structure
- Shared package spi_pkg: state enum (IDLE, SETUP, SHIFT, TRAIL, GAP), polarity constants, index-width helper function.
- One sub-module: spi_rr_arbiter (request vector, pointer update on grant, one-hot grant + index out); contains the macro switch.

## Test plan
- Single request on 2, sdi serializes 0xA5C3 MSB first, half_period 4 -> ss active 136 cycles, data 0xA5C3, data_channel 2, one data_valid pulse.
- Requests 0 and 3 held continuously -> grants alternate 0,3,0,3; fixed-priority build -> grant always 0.
- All four requests simultaneously -> grants 0,1,2,3 in order, four data_valid pulses, no overlap of ss activity.
- msb_first 0, sdi stream 1,0,0,0…0 -> data 0x0001; sclk_polarity 0 -> sclk idles low, same data.
- reset_n low at edge 10 of SHIFT -> ss inactive, sclk idle, grant 0 immediately, no data_valid; after release new transfer begins from IDLE.
- Request dropped during SHIFT -> transfer completes, data_valid still pulses with correct channel.
